can_stuff_tx: RTL and testbench
===============================

Name: can_stuff_tx

Overview:
Transmit-side CAN bit stuffer and bit-timer. It is the counterpart of can_destuff on the receive path. It accepts frame bits one at a time through a valid/ready handshake and drives them onto the serial line, CLKS_PER_BIT clocks per bit. After five consecutive identical stuff-enabled bits it inserts a complementary stuff bit. It sits between the frame builder (SOF..CRC bits) and the bus driver; idle/recessive level is 1.

Parameters:
CLKS_PER_BIT, 10, clocks per nominal bit time (>=2)
STUFF_RUN, 5, consecutive identical bits that trigger a stuff bit

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Bit_DV  in  1  i_Bit is valid this cycle
i_Bit  in  1  frame bit to send (0 = dominant)
i_Stuff_En  in  1  sampled with i_Bit; 1 = bit participates in stuffing (SOF..CRC), 0 = exempt (CRC delim, ACK, EOF)
o_Bit_Ready  out  1  block accepts i_Bit this cycle
o_Tx_Serial  out  1  serial CAN output
o_Stuff_Active  out  1  high for the whole period of an inserted stuff bit
o_Busy  out  1  high while a data or stuff bit is on the line
o_Stuff_Cnt  out  8  stuff bits inserted in the current frame, saturates at 255

Behaviour:
- Reset (async, i_Rst_n=0): state IDLE, o_Tx_Serial=1, o_Bit_Ready=1, o_Stuff_Active=0, o_Busy=0, o_Stuff_Cnt=0, run counter=0, last-bit register=1, clock counter=0. Applies immediately, including mid-bit; no partial bit is completed.
- States: IDLE, DATA, STUFF. Clock counter runs 0..CLKS_PER_BIT-1 in DATA/STUFF.
- Handshake: a transfer occurs on a rising edge with i_Bit_DV & o_Bit_Ready. i_Bit and i_Stuff_En are captured on that edge. o_Bit_Ready is combinational from state/counters only, never from i_Bit_DV.
- o_Bit_Ready=1 in IDLE. It is also 1 in the last clock (count==CLKS_PER_BIT-1) of a DATA or STUFF bit when no stuff bit is pending. It is 0 otherwise.
- Latency: an accepted bit appears on o_Tx_Serial at the next edge and is held exactly CLKS_PER_BIT clocks. Back-to-back transfers give a gapless bit stream.
- Run tracking on accepting a bit with i_Stuff_En=1:
  - bit==last: run=run+1.
  - otherwise: run=1, last=bit.
- Accepting a bit with i_Stuff_En=0 sets run=0 (exempt bits never trigger or seed stuffing).
- Stuff pending when run==STUFF_RUN after a DATA bit. At the end of that DATA bit the state goes to STUFF with o_Tx_Serial=~last for CLKS_PER_BIT clocks. Then run=1 and last=~last, because the stuff bit seeds the next run per CAN rules.
  - o_Stuff_Active=1 throughout the STUFF bit.
  - o_Stuff_Cnt increments on STUFF entry.
- A pending stuff bit is always sent, even if no further bit is offered.
- At the end of any bit (DATA or STUFF, no stuff pending) with no transfer: go to IDLE, o_Tx_Serial=1, o_Busy=0, run=0, last=1.
- o_Stuff_Cnt clears on the IDLE->DATA transition (new frame). It holds its value while IDLE so it can be read after a frame.
- i_Bit_DV while o_Bit_Ready=0 is ignored; the source must hold it.
- o_Busy=1 in DATA and STUFF.

Test Plan:
(CLKS_PER_BIT=10, all bits i_Stuff_En=1 unless stated.)
1. Reset with i_Bit_DV=0 -> o_Tx_Serial=1, o_Bit_Ready=1, o_Busy=0, o_Stuff_Cnt=0.
2. Send 0,0,0,0,0 back-to-back, then stop offering bits.
   - Line shows 0 for 50 clocks, then 1 for 10 clocks with o_Stuff_Active=1, then idle 1.
   - o_Bit_Ready=0 in the last clock of the 5th bit.
   - o_Stuff_Cnt=1.
3. Send 0,0,0,0,0,1,1,1,1 -> wire sequence 0,0,0,0,0,[1],1,1,1,1,[0] (110 clocks), o_Stuff_Cnt=2. This confirms the stuff bit counts toward the following run.
4. Send ten 0s -> wire 00000[1]00000[1], 120 clocks, o_Stuff_Cnt=2. Alternating 01010101 -> 80 clocks, no stuff, o_Stuff_Cnt=0.
5. Send 1,1,1,1,1,1,1 with i_Stuff_En=0 (EOF) -> 70 clocks of 1, no stuff, o_Stuff_Active never 1.
6. Assert i_Rst_n=0 at clock 4 of a stuff bit -> o_Tx_Serial=1 and o_Stuff_Active=0 immediately. After release, state is IDLE, o_Stuff_Cnt=0, and the next frame's first bit does not inherit the old run.

Source files
------------

// File: rtl/can_stuff_tx.sv
// rtl/can_stuff_tx.sv - transmit-side CAN bit stuffer and bit timer
module can_stuff_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int STUFF_RUN    = 5
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Bit_DV,
    input  logic       i_Bit,
    input  logic       i_Stuff_En,
    output logic       o_Bit_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Stuff_Active,
    output logic       o_Busy,
    output logic [7:0] o_Stuff_Cnt
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int RW = $clog2(STUFF_RUN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(STUFF_RUN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   run;
    logic            last;
    logic            tx;
    logic [7:0]      stuff_cnt;
    logic            bit_end;
    logic            stuff_pending;
    logic            ready;
    logic            xfer;

    // Handshake and next-state decode; ready depends only on state and counters.
    always_comb begin
        bit_end       = 1'b0;
        stuff_pending = 1'b0;
        ready         = 1'b0;
        xfer          = 1'b0;
        state_next    = state;

        bit_end       = (state != IDLE) && (cnt == CNT_LAST);
        stuff_pending = (state == DATA) && (run == RUN_MAX);
        ready         = (state == IDLE) || (bit_end && !stuff_pending);
        xfer          = i_Bit_DV && ready;

        if (xfer) begin
            state_next = DATA;
        end else if (bit_end) begin
            state_next = stuff_pending ? STUFF : IDLE;
        end
    end

    // State register.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit timer, line driver, run tracking and per-frame stuff counter.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt       <= '0;
            run       <= '0;
            last      <= 1'b1;
            tx        <= 1'b1;
            stuff_cnt <= 8'd0;
        end else if (xfer) begin
            cnt <= '0;
            tx  <= i_Bit;
            if (state == IDLE) begin
                stuff_cnt <= 8'd0;
            end
            if (i_Stuff_En) begin
                if (i_Bit == last) begin
                    run <= run + RW'(1);
                end else begin
                    run  <= RW'(1);
                    last <= i_Bit;
                end
            end else begin
                // Exempt bits break any run so they never trigger stuffing.
                run <= '0;
            end
        end else if (bit_end) begin
            cnt <= '0;
            if (stuff_pending) begin
                // The stuff bit itself starts the next run.
                tx   <= ~last;
                last <= ~last;
                run  <= RW'(1);
                if (stuff_cnt != 8'hFF) begin
                    stuff_cnt <= stuff_cnt + 8'd1;
                end
            end else begin
                tx   <= 1'b1;
                run  <= '0;
                last <= 1'b1;
            end
        end else if (state != IDLE) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign o_Bit_Ready    = ready;
    assign o_Tx_Serial    = tx;
    assign o_Stuff_Active = (state == STUFF);
    assign o_Busy         = (state != IDLE);
    assign o_Stuff_Cnt    = stuff_cnt;

endmodule

// File: tb/tb_can_stuff_tx.sv
// tb/tb_can_stuff_tx.sv - directed self-checking bench for can_stuff_tx
module tb_can_stuff_tx;

    localparam int CPB = 10;

    logic       i_Clock = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_Bit_DV = 1'b0;
    logic       i_Bit = 1'b1;
    logic       i_Stuff_En = 1'b1;
    logic       o_Bit_Ready;
    logic       o_Tx_Serial;
    logic       o_Stuff_Active;
    logic       o_Busy;
    logic [7:0] o_Stuff_Cnt;

    int checks = 0;
    int failures = 0;

    logic cap_tx  [$];
    logic cap_sa  [$];
    logic cap_rdy [$];

    can_stuff_tx #(.CLKS_PER_BIT(CPB), .STUFF_RUN(5)) dut (
        .i_Clock        (i_Clock),
        .i_Rst_n        (i_Rst_n),
        .i_Bit_DV       (i_Bit_DV),
        .i_Bit          (i_Bit),
        .i_Stuff_En     (i_Stuff_En),
        .o_Bit_Ready    (o_Bit_Ready),
        .o_Tx_Serial    (o_Tx_Serial),
        .o_Stuff_Active (o_Stuff_Active),
        .o_Busy         (o_Busy),
        .o_Stuff_Cnt    (o_Stuff_Cnt)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Offer each bit of a '0'/'1' string and hold it until accepted.
    task automatic send(input string bits, input logic en);
        for (int i = 0; i < bits.len(); i++) begin
            int n;
            n = 0;
            i_Bit_DV   = 1'b1;
            i_Bit      = (bits[i] == "1");
            i_Stuff_En = en;
            while (!o_Bit_Ready && n < 100) begin
                @(negedge i_Clock);
                n++;
            end
            if (n >= 100) check("ready_timeout", 32'(n), 0);
            @(posedge i_Clock);
            #1;
        end
        i_Bit_DV = 1'b0;
    endtask

    // Record the line at every falling edge while the block is busy.
    task automatic capture();
        int n;
        n = 0;
        cap_tx.delete();
        cap_sa.delete();
        cap_rdy.delete();
        @(negedge i_Clock);
        while (!o_Busy && n < 50) begin
            @(negedge i_Clock);
            n++;
        end
        while (o_Busy && cap_tx.size() < 400) begin
            cap_tx.push_back(o_Tx_Serial);
            cap_sa.push_back(o_Stuff_Active);
            cap_rdy.push_back(o_Bit_Ready);
            @(negedge i_Clock);
        end
    endtask

    task automatic run_frame(input string name, input string bits, input logic en,
                             input string exp_wire, input string exp_stuff,
                             input int exp_cnt);
        int wire_err;
        int sa_err;
        fork
            send(bits, en);
            capture();
        join
        wire_err = 0;
        sa_err   = 0;
        check({name, "_len"}, 32'(cap_tx.size()), 32'(exp_wire.len() * CPB));
        for (int k = 0; k < cap_tx.size() && k < exp_wire.len() * CPB; k++) begin
            if (cap_tx[k] !== (exp_wire[k / CPB] == "1")) wire_err++;
            if (cap_sa[k] !== (exp_stuff[k / CPB] == "1")) sa_err++;
        end
        check({name, "_wire_errs"}, 32'(wire_err), 0);
        check({name, "_stuff_active_errs"}, 32'(sa_err), 0);
        check({name, "_stuff_cnt"}, 32'(o_Stuff_Cnt), 32'(exp_cnt));
        check({name, "_idle_tx"}, 32'(o_Tx_Serial), 1);
        check({name, "_idle_ready"}, 32'(o_Bit_Ready), 1);
    endtask

    initial begin
        int n;

        // Reset with no bits offered.
        repeat (3) @(negedge i_Clock);
        check("rst_tx", 32'(o_Tx_Serial), 1);
        check("rst_ready", 32'(o_Bit_Ready), 1);
        check("rst_busy", 32'(o_Busy), 0);
        check("rst_stuff_cnt", 32'(o_Stuff_Cnt), 0);
        check("rst_stuff_active", 32'(o_Stuff_Active), 0);
        i_Rst_n = 1'b1;
        @(posedge i_Clock);
        #1;

        // Five dominant bits then a recessive stuff bit.
        run_frame("five_zeros", "00000", 1'b1, "000001", "000001", 1);
        if (cap_rdy.size() >= 50) begin
            check("five_zeros_ready_bit4_last", 32'(cap_rdy[39]), 1);
            check("five_zeros_ready_bit5_last", 32'(cap_rdy[49]), 0);
        end else begin
            check("five_zeros_capture_short", 32'(cap_rdy.size()), 50);
        end

        // Stuff bit seeds the following run.
        run_frame("seed", "000001111", 1'b1, "00000111110", "00000100001", 2);

        // Ten dominant bits: two stuff bits.
        run_frame("ten_zeros", "0000000000", 1'b1, "000001000001", "000001000001", 2);

        // Alternating bits: no stuffing, counter cleared by the new frame.
        run_frame("alt", "01010101", 1'b1, "01010101", "00000000", 0);

        // Exempt recessive bits (EOF) never stuff.
        run_frame("eof", "1111111", 1'b0, "1111111", "0000000", 0);

        // Asynchronous reset in the middle of a stuff bit.
        fork
            send("00000", 1'b1);
        join
        n = 0;
        while (!o_Stuff_Active && n < 50) begin
            @(negedge i_Clock);
            n++;
        end
        check("rst_mid_reach_stuff", 32'(o_Stuff_Active), 1);
        repeat (4) @(posedge i_Clock);
        #2;
        i_Rst_n = 1'b0;
        #1;
        check("rst_mid_tx", 32'(o_Tx_Serial), 1);
        check("rst_mid_stuff_active", 32'(o_Stuff_Active), 0);
        check("rst_mid_busy", 32'(o_Busy), 0);
        check("rst_mid_ready", 32'(o_Bit_Ready), 1);
        repeat (2) @(negedge i_Clock);
        i_Rst_n = 1'b1;
        @(negedge i_Clock);
        check("rst_mid_stuff_cnt", 32'(o_Stuff_Cnt), 0);
        check("rst_mid_idle_busy", 32'(o_Busy), 0);
        @(posedge i_Clock);
        #1;

        // Four recessive bits after reset must not complete an inherited run.
        run_frame("post_rst", "1111", 1'b1, "1111", "0000", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
